// File: rtl/arm_cond_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arm_cond_pkg
// Brief    : Shared constants for the ARM condition-code checker: COND field
//            encodings, NZCV flag bit positions and FSM state encoding.
// Revision : 1.0 - initial release
// ============================================================================
package arm_cond_pkg;

    // ARM condition field encodings
    localparam logic [3:0] COND_EQ = 4'b0000;
    localparam logic [3:0] COND_NE = 4'b0001;
    localparam logic [3:0] COND_CS = 4'b0010;
    localparam logic [3:0] COND_CC = 4'b0011;
    localparam logic [3:0] COND_MI = 4'b0100;
    localparam logic [3:0] COND_PL = 4'b0101;
    localparam logic [3:0] COND_VS = 4'b0110;
    localparam logic [3:0] COND_VC = 4'b0111;
    localparam logic [3:0] COND_HI = 4'b1000;
    localparam logic [3:0] COND_LS = 4'b1001;
    localparam logic [3:0] COND_GE = 4'b1010;
    localparam logic [3:0] COND_LT = 4'b1011;
    localparam logic [3:0] COND_GT = 4'b1100;
    localparam logic [3:0] COND_LE = 4'b1101;
    localparam logic [3:0] COND_AL = 4'b1110;
    localparam logic [3:0] COND_NV = 4'b1111;

    // Bit positions inside the NZCV flag register
    localparam int N_BIT = 3;
    localparam int Z_BIT = 2;
    localparam int C_BIT = 1;
    localparam int V_BIT = 0;

    // Request-handling FSM states
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        EVAL = 2'd2
    } state_t;

endpackage : arm_cond_pkg
`default_nettype wire

// File: rtl/cond_decode.sv
`default_nettype none
// ============================================================================
// Module   : cond_decode
// Brief    : Purely combinational ARM condition evaluator. Maps a 4-bit COND
//            field and the NZCV flags to a single pass/fail result.
// Revision : 1.0 - initial release
// ============================================================================
module cond_decode
    import arm_cond_pkg::*;
(
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       result
);

    logic n;
    logic z;
    logic c;
    logic v;

    assign n = flags[N_BIT];
    assign z = flags[Z_BIT];
    assign c = flags[C_BIT];
    assign v = flags[V_BIT];

    // Condition table lookup
    always_comb begin
        result = 1'b0;
        case (cond)
            COND_EQ: result = z;
            COND_NE: result = ~z;
            COND_CS: result = c;
            COND_CC: result = ~c;
            COND_MI: result = n;
            COND_PL: result = ~n;
            COND_VS: result = v;
            COND_VC: result = ~v;
            COND_HI: result = c & ~z;
            COND_LS: result = ~c | z;
            COND_GE: result = (n == v);
            COND_LT: result = (n != v);
            COND_GT: result = ~z & (n == v);
            COND_LE: result = z | (n != v);
            COND_AL: result = 1'b1;
            COND_NV: result = 1'b0;
            default: result = 1'b0;
        endcase
    end

endmodule : cond_decode
`default_nettype wire

// File: rtl/cond_check_unit.sv
`default_nettype none
// ============================================================================
// Module   : cond_check_unit
// Brief    : Condition-code checker between decode and the flag register.
//            Tracks in-flight flag writers, stalls requests whose flags are
//            not yet final and answers the rest with a registered PASS/ACK.
// Revision : 1.0 - initial release
// ============================================================================
module cond_check_unit
    import arm_cond_pkg::*;
#(
    parameter int MAX_PEND = 3
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic [3:0] FLAGS,
    input  logic       SET_PEND,
    input  logic       FLAG_WR,
    input  logic       REQ,
    input  logic [3:0] COND,
    output logic       ACK,
    output logic       PASS,
    output logic       STALL,
    output logic [1:0] PENDING,
    output logic       ERR
);

    localparam logic [1:0] PEND_MAX = 2'(MAX_PEND);

    state_t     state;
    logic [3:0] cond_q;
    logic [1:0] pend_next;
    logic       overflow;
    logic       cond_result;
    logic       no_hazard;

    cond_decode u_cond_decode (
        .cond   (cond_q),
        .flags  (FLAGS),
        .result (cond_result)
    );

    // Next pending count; simultaneous SET_PEND and FLAG_WR cancel out
    always_comb begin
        pend_next = PENDING;
        overflow  = 1'b0;
        if (SET_PEND && !FLAG_WR) begin
            if (PENDING == PEND_MAX) begin
                overflow = 1'b1;
            end else begin
                pend_next = PENDING + 2'd1;
            end
        end else if (FLAG_WR && !SET_PEND) begin
            if (PENDING != 2'd0) begin
                pend_next = PENDING - 2'd1;
            end
        end
    end

    // AL/NV never depend on flags, so they bypass the hazard check
    assign no_hazard = (COND == COND_AL) || (COND == COND_NV) || (PENDING == 2'd0);

    // Pending-writer counter and sticky overflow flag
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            PENDING <= 2'd0;
            ERR     <= 1'b0;
        end else begin
            PENDING <= pend_next;
            if (overflow) begin
                ERR <= 1'b1;
            end
        end
    end

    // Request FSM with COND latch and registered ACK/PASS
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state  <= IDLE;
            cond_q <= 4'd0;
            ACK    <= 1'b0;
            PASS   <= 1'b0;
        end else begin
            ACK <= 1'b0;
            case (state)
                IDLE: begin
                    if (REQ) begin
                        cond_q <= COND;
                        state  <= no_hazard ? EVAL : WAIT;
                    end
                end
                WAIT: begin
                    // Leave on the edge that retires the last writer so that
                    // the first cycle with PENDING==0 is already EVAL
                    if (pend_next == 2'd0) begin
                        state <= EVAL;
                    end
                end
                EVAL: begin
                    PASS  <= cond_result;
                    ACK   <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign STALL = (state == WAIT);

endmodule : cond_check_unit
`default_nettype wire
